// File: rtl/control_debug_pipeline.sv
// Debug sequencer for the MIPS pipeline: free-run / single-step gating of the
// pipeline enable, halt capture, and a byte-serial dump of the register file.
module control_debug_pipeline #(
    parameter int LEN                  = 32,
    parameter int CANTIDAD_REGISTROS   = 32,
    parameter int NB_ADDRESS_REGISTROS = $clog2(CANTIDAD_REGISTROS)
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_cmd_valid,
    input  logic [1:0]                      i_cmd,
    output logic                            o_cmd_ready,
    input  logic                            i_halt,
    output logic                            o_pipe_en,
    output logic                            o_halted,
    output logic                            o_rf_sel,
    output logic [NB_ADDRESS_REGISTROS-1:0] o_rf_addr,
    input  logic [LEN-1:0]                  i_rf_data,
    output logic [7:0]                      o_tx_data,
    output logic                            o_tx_valid,
    input  logic                            i_tx_ready
);

    localparam int NB_BYTES = LEN / 8;
    localparam int NB_CNT   = $clog2(NB_BYTES) + 1;
    localparam logic [NB_CNT-1:0]               LAST_BYTE = NB_CNT'(NB_BYTES - 1);
    localparam logic [NB_ADDRESS_REGISTROS-1:0] LAST_ADDR = NB_ADDRESS_REGISTROS'(CANTIDAD_REGISTROS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_DUMP_RD,
        S_DUMP_TX
    } state_t;

    typedef enum logic [1:0] {
        CMD_NOP,
        CMD_RUN,
        CMD_STEP,
        CMD_DUMP
    } cmd_t;

    state_t                          state_q, state_d;
    logic                            halted_q, halted_d;
    logic [NB_ADDRESS_REGISTROS-1:0] addr_q, addr_d;
    logic [LEN-1:0]                  shreg_q, shreg_d;
    logic [NB_CNT-1:0]               cnt_q, cnt_d;
    logic                            cmd_ready_q, cmd_ready_d;
    logic                            pipe_en_q, pipe_en_d;
    logic                            rf_sel_q, rf_sel_d;
    logic                            tx_valid_q, tx_valid_d;

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        addr_d   = addr_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    unique case (cmd_t'(i_cmd))
                        CMD_RUN:  if (!halted_q) state_d = S_RUN;
                        CMD_STEP: if (!halted_q) state_d = S_STEP;
                        CMD_DUMP: begin
                            addr_d  = '0;
                            state_d = S_DUMP_RD;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (i_halt) begin
                    halted_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_STEP: begin
                if (i_halt) halted_d = 1'b1;
                state_d = S_IDLE;
            end
            S_DUMP_RD: begin
                shreg_d = i_rf_data;
                cnt_d   = '0;
                state_d = S_DUMP_TX;
            end
            S_DUMP_TX: begin
                if (i_tx_ready) begin
                    shreg_d = shreg_q >> 8;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BYTE) begin
                        if (addr_q == LAST_ADDR) begin
                            addr_d  = '0;
                            state_d = S_IDLE;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = S_DUMP_RD;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered images of the next state, so they
        // depend on inputs only through the flops.
        cmd_ready_d = (state_d == S_IDLE);
        pipe_en_d   = (state_d == S_RUN) || (state_d == S_STEP);
        rf_sel_d    = (state_d == S_DUMP_RD) || (state_d == S_DUMP_TX);
        tx_valid_d  = (state_d == S_DUMP_TX);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            halted_q    <= 1'b0;
            addr_q      <= '0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            pipe_en_q   <= 1'b0;
            rf_sel_q    <= 1'b0;
            tx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            halted_q    <= halted_d;
            addr_q      <= addr_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            pipe_en_q   <= pipe_en_d;
            rf_sel_q    <= rf_sel_d;
            tx_valid_q  <= tx_valid_d;
        end
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_pipe_en   = pipe_en_q;
    assign o_halted    = halted_q;
    assign o_rf_sel    = rf_sel_q;
    assign o_rf_addr   = addr_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_tx_data   = shreg_q[7:0];

endmodule

// File: doc/control_debug_pipeline.md
# control_debug_pipeline

Debug sequencer for the MIPS pipeline. It gates the pipeline clock-enable for free-run and single-step execution. It stops the pipeline on a halt instruction. On command, it takes over register-file read port 1 and streams all registers out as a byte stream with a valid/ready handshake. It sits between the external debug command source (UART receiver/transmitter) and the pipeline's enables and the register bank's read-address mux in the decode stage.

## Interface
Parameters:
- LEN, 32, register data width (bits)
- CANTIDAD_REGISTROS, 32, number of registers dumped
- NB_ADDRESS_REGISTROS, $clog2(CANTIDAD_REGISTROS), register address width

Ports:
- i_clk  in  1  single clock; all state updates on rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_cmd_valid  in  1  command present
- i_cmd  in  2  00 NOP, 01 RUN, 10 STEP, 11 DUMP
- o_cmd_ready  out  1  command accepted on edge where i_cmd_valid & o_cmd_ready
- i_halt  in  1  halt instruction decoded in the pipeline (level)
- o_pipe_en  out  1  pipeline register/PC enable
- o_halted  out  1  sticky: halt reached
- o_rf_sel  out  1  1 = debug owns register-file read port 1
- o_rf_addr  out  NB_ADDRESS_REGISTROS  debug read address
- i_rf_data  in  LEN  read port 1 data (combinational from o_rf_addr)
- o_tx_data  out  8  byte to transmitter
- o_tx_valid  out  1  byte valid
- i_tx_ready  in  1  transmitter accepts byte

## Operation
- States: IDLE, RUN, STEP, DUMP_RD, DUMP_TX.
- Reset (async, i_rst=0) puts the block in IDLE. All outputs go to 0 except o_cmd_ready=1: o_pipe_en, o_halted, o_rf_sel, o_rf_addr, o_tx_valid, o_tx_data, byte counter.
- o_cmd_ready = 1 only in IDLE. Commands presented in other states are not consumed.
- o_pipe_en = 1 only in RUN and STEP. It is decoded from the state, with no combinational path from inputs.
- o_rf_sel = 1 only in DUMP_RD and DUMP_TX.
- IDLE behaviour on an accepted command:
  - RUN: go to RUN if o_halted=0.
  - STEP: go to STEP if o_halted=0.
  - DUMP: clear o_rf_addr to 0 and go to DUMP_RD.
  - NOP, or RUN/STEP with o_halted=1: consumed, stay in IDLE.
- RUN: stay in RUN while i_halt=0. On an edge with i_halt=1, set o_halted=1 and go to IDLE.
- STEP: exactly one cycle, then IDLE. If i_halt=1 at that edge, set o_halted=1.
- DUMP_RD: one cycle. Latch i_rf_data into a LEN-bit shift register, clear the byte counter, go to DUMP_TX.
- DUMP_TX:
  - o_tx_valid=1 and o_tx_data = shift register [7:0]. Bytes go out LSB first.
  - On tx_valid & tx_ready: shift right 8 bits and increment the counter.
  - After byte LEN/8-1 is accepted:
    - If o_rf_addr = CANTIDAD_REGISTROS-1: go to IDLE, clear o_rf_addr to 0, drop o_tx_valid.
    - Otherwise: o_rf_addr+1, go to DUMP_RD.
  - While i_tx_ready=0, o_tx_data and o_tx_valid are held stable.
- o_halted is cleared only by reset. DUMP is still allowed while halted.
- o_rf_addr wraps only via the explicit clear. It never increments past CANTIDAD_REGISTROS-1.

## Timing
- RUN/STEP accepted at edge N. o_pipe_en is high from edge N to edge N+1 (STEP) or until the edge sampling i_halt=1 (RUN). That edge still advances the pipeline.
- DUMP accepted at edge N: DUMP_RD during N..N+1, first o_tx_valid=1 after N+1.
- Per register: 1 read cycle + LEN/8 handshakes. The minimum dump with i_tx_ready stuck at 1 is CANTIDAD_REGISTROS*(1+LEN/8) = 160 cycles, and 128 bytes are transferred.
- o_tx_valid is low during DUMP_RD, giving one bubble between registers.
- Reset mid-dump or mid-run: all outputs are forced to reset values immediately (asynchronous). No partial byte is held.
- i_cmd_valid held high across commands: one command is consumed per IDLE edge.

## Test plan
- Reset values: assert i_rst=0 mid-RUN → o_pipe_en=0 and o_cmd_ready=1 at once, with no clock needed. After release, o_halted=0 and o_rf_addr=0.
- STEP: three STEP commands with i_halt=0 → exactly 3 single-cycle o_pipe_en pulses, back in IDLE after each.
- RUN then halt: RUN, raise i_halt 10 cycles later → o_pipe_en high 11 cycles, o_halted=1. A following RUN is consumed and o_pipe_en stays 0.
- DUMP, ready always 1: register model returns data = 0x11111111*addr → 128 bytes in order (addr 0 byte 0 first, LSB first). Total 160 cycles. o_rf_sel=0 and o_rf_addr=0 afterwards.
- DUMP with backpressure: random i_tx_ready (50%) → byte order unchanged. o_tx_data stable while valid & !ready. o_cmd_ready=0 throughout.
- Command during DUMP: assert STEP mid-dump → not accepted until the dump ends, then o_pipe_en pulses once.
